// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch (rom_*) and data (ram_*) ports; the data access always goes first.
// Latency: stall is 1 + (1 + ack wait cycles) per enabled port; DONE presents the read data. Backpressure: the memory throttles through mem_ack.
// Optional MEM_ARB_PERF_EN: adds the saturating perf_stall_cycles counter.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_en,
    input  logic [SEL_WIDTH-1:0]  rom_write_en,
    input  logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_write_data,
    output logic [DATA_WIDTH-1:0] rom_read_data,
    input  logic                  ram_en,
    input  logic [SEL_WIDTH-1:0]  ram_write_en,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  stall,
    output logic                  mem_req,
    output logic [SEL_WIDTH-1:0]  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]           perf_stall_cycles,
`endif
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, DATA, INST, DONE} state_t;

    state_t                  state;
    logic                    rom_en_q;
    logic [SEL_WIDTH-1:0]    rom_write_en_q;
    logic [ADDR_WIDTH-1:0]   rom_addr_q;
    logic [DATA_WIDTH-1:0]   rom_write_data_q;
    logic [DATA_WIDTH-1:0]   rom_q;
    logic [DATA_WIDTH-1:0]   ram_q;

    assign rom_read_data = rom_q;
    assign ram_read_data = ram_q;

    // Stall must be low in the reset cycle even though IDLE sees live enables.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:       stall = rom_en | ram_en;
                DATA, INST: stall = 1'b1;
                default:    stall = 1'b0;
            endcase
        end
    end

    // The mem_* registers double as the latched copy of the ram request while in DATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            mem_req          <= 1'b0;
            mem_write_en     <= '0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
            rom_en_q         <= 1'b0;
            rom_write_en_q   <= '0;
            rom_addr_q       <= '0;
            rom_write_data_q <= '0;
            rom_q            <= '0;
            ram_q            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rom_en_q         <= rom_en;
                    rom_write_en_q   <= rom_write_en;
                    rom_addr_q       <= rom_addr;
                    rom_write_data_q <= rom_write_data;
                    if (ram_en) begin
                        state          <= DATA;
                        mem_req        <= 1'b1;
                        mem_write_en   <= ram_write_en;
                        mem_addr       <= ram_addr;
                        mem_write_data <= ram_write_data;
                    end else if (rom_en) begin
                        state          <= INST;
                        mem_req        <= 1'b1;
                        mem_write_en   <= rom_write_en;
                        mem_addr       <= rom_addr;
                        mem_write_data <= rom_write_data;
                    end
                end
                DATA: begin
                    if (mem_ack) begin
                        if (mem_write_en == '0)
                            ram_q <= mem_read_data;
                        if (rom_en_q) begin
                            state          <= INST;
                            mem_write_en   <= rom_write_en_q;
                            mem_addr       <= rom_addr_q;
                            mem_write_data <= rom_write_data_q;
                        end else begin
                            state          <= DONE;
                            mem_req        <= 1'b0;
                            mem_write_en   <= '0;
                            mem_addr       <= '0;
                            mem_write_data <= '0;
                        end
                    end
                end
                INST: begin
                    if (mem_ack) begin
                        if (mem_write_en == '0)
                            rom_q <= mem_read_data;
                        state          <= DONE;
                        mem_req        <= 1'b0;
                        mem_write_en   <= '0;
                        mem_addr       <= '0;
                        mem_write_data <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_stall_cycles <= '0;
        else if (stall && perf_stall_cycles != 32'hFFFF_FFFF)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected memory accesses and stall results.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_en = 1'b0;
    logic [3:0]  rom_write_en = '0;
    logic [31:0] rom_addr = '0;
    logic [31:0] rom_write_data = '0;
    logic [31:0] rom_read_data;
    logic        ram_en = 1'b0;
    logic [3:0]  ram_write_en = '0;
    logic [31:0] ram_addr = '0;
    logic [31:0] ram_write_data = '0;
    logic [31:0] ram_read_data;
    logic        stall;
    logic        mem_req;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_read_data = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .rom_en(rom_en), .rom_write_en(rom_write_en), .rom_addr(rom_addr),
        .rom_write_data(rom_write_data), .rom_read_data(rom_read_data),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .stall(stall), .mem_req(mem_req), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
`ifdef MEM_ARB_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .mem_ack(mem_ack), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
    } acc_t;

    typedef struct {
        int          stalls;
        logic [31:0] rom;
        logic [31:0] ram;
    } res_t;

    acc_t exp_acc[$];
    res_t exp_res[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [31:0] rom_m = '0;
    logic [31:0] ram_m = '0;
    bit   done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: accesses on ack, stability during waits, idle bus zeros, and results on stall release.
    initial begin
        int cnt = 0;
        acc_t a;
        res_t r;
        while (!done) begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
            end else begin
                if (mem_req) begin
                    if (exp_acc.size() == 0) begin
                        check("unexpected_access", 32'd1, 32'd0);
                    end else begin
                        a = exp_acc[0];
                        check(mem_ack ? "acc_addr" : "hold_addr", mem_addr, a.addr);
                        check(mem_ack ? "acc_we" : "hold_we", {28'd0, mem_write_en}, {28'd0, a.we});
                        check(mem_ack ? "acc_wd" : "hold_wd", mem_write_data, a.wd);
                        if (mem_ack) void'(exp_acc.pop_front());
                    end
                end else begin
                    check("idle_bus_zero", {mem_addr | mem_write_data}, 32'd0);
                    check("idle_we_zero", {28'd0, mem_write_en}, 32'd0);
                end
                if (stall) begin
                    cnt++;
                end else if (cnt > 0) begin
                    if (exp_res.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        r = exp_res.pop_front();
                        check("stall_cycles", cnt, r.stalls);
                        check("rom_read_data", rom_read_data, r.rom);
                        check("ram_read_data", ram_read_data, r.ram);
                    end
                    cnt = 0;
                end
            end
        end
    end

    task automatic wait_req();
        int t = 0;
        while (!mem_req && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!mem_req) check("mem_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input int waits, input logic [31:0] d);
        wait_req();
        mem_ack = 1'b0;
        repeat (waits) begin @(posedge clk); #1; end
        mem_ack = 1'b1;
        mem_read_data = d;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_read_data = '0;
    endtask

    task automatic txn(input logic re, input logic [3:0] rwe, input logic [31:0] ra,
                       input logic [31:0] rwd, input logic [31:0] rrd, input int rw,
                       input logic fe, input logic [31:0] fa, input logic [31:0] frd, input int fw);
        res_t r;
        int   s = 1;
        if (re) begin
            exp_acc.push_back('{addr: ra, we: rwe, wd: rwd});
            if (rwe == 4'b0) ram_m = rrd;
            s += 1 + rw;
        end
        if (fe) begin
            exp_acc.push_back('{addr: fa, we: 4'b0, wd: 32'h0});
            rom_m = frd;
            s += 1 + fw;
        end
        r.stalls = s; r.rom = rom_m; r.ram = ram_m;
        exp_res.push_back(r);
        ram_en = re; ram_write_en = rwe; ram_addr = ra; ram_write_data = rwd;
        rom_en = fe; rom_write_en = 4'b0; rom_addr = fa; rom_write_data = '0;
        @(posedge clk); #1;
        if (re) serve(rw, rrd);
        if (fe) serve(fw, frd);
        ram_en = 1'b0; rom_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        // Reset held with a fetch request pending.
        rom_en = 1'b1; rom_addr = 32'h100;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_stall", {31'd0, stall}, 32'd0);
            check("rst_mem_req", {31'd0, mem_req}, 32'd0);
            check("rst_rom_data", rom_read_data, 32'd0);
        end
        rom_en = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst_stall", {31'd0, stall}, 32'd0);

        // Load then fetch, then fetch only.
        txn(1'b1, 4'b0, 32'h2000, 32'h0, 32'hDEADBEEF, 0, 1'b1, 32'h104, 32'h0000_0000, 0);
        txn(1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h100, 32'h3C010001, 0);
`ifdef MEM_ARB_PERF_EN
        check("perf_stall_cycles", perf_stall_cycles, 32'd5);
`endif
        // Store with 3 ack wait cycles: read data must not reach ram_q.
        txn(1'b1, 4'b0011, 32'h3000, 32'h1234, 32'hFFFF, 3, 1'b0, 32'h0, 32'h0, 0);
        txn(1'b1, 4'b1111, 32'h10, 32'hCAFEF00D, 32'h1111_1111, 1, 1'b1, 32'h108, 32'h8C220004, 2);
        txn(1'b1, 4'b0, 32'h44, 32'h0, 32'h0BADF00D, 2, 1'b1, 32'h10C, 32'h24420001, 0);

        // Reset while the data access waits for ack; a late ack must be ignored.
        exp_acc.push_back('{addr: 32'h2004, we: 4'b0, wd: 32'h0});
        ram_en = 1'b1; ram_addr = 32'h2004; ram_write_en = 4'b0;
        @(posedge clk); #1;
        check("mid_req_up", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; ram_en = 1'b0;
        @(posedge clk); #1;
        check("mid_req_dropped", {31'd0, mem_req}, 32'd0);
        exp_acc.delete();
        rom_m = '0; ram_m = '0;
        rst = 1'b0;
        mem_ack = 1'b1; mem_read_data = 32'h5555_5555;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_read_data = '0;
        @(posedge clk); #1;
        check("late_ack_ram_q", ram_read_data, ram_m);
        check("late_ack_stall", {31'd0, stall}, 32'd0);
        check("late_ack_req", {31'd0, mem_req}, 32'd0);

        t = 0;
        while ((exp_acc.size() != 0 || exp_res.size() != 0) && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        check("acc_queue_drained", exp_acc.size(), 32'd0);
        check("res_queue_drained", exp_res.size(), 32'd0);
        done = 1'b1;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
